// File: rtl/udp_coef_sender.sv
// ============================================================================
// Module      : udp_coef_sender
// Description : Serialises one biquad coefficient set {filt,b0,b1,b2,a1,a2}
//               into a 21-byte UDP payload, MSB first, on a valid/ready/last
//               byte stream. Holds one active frame plus one pending request.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module udp_coef_sender #(
  parameter int FILT_NUM = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_send,
  input  logic [7:0]  i_filt,
  input  logic [31:0] i_b0,
  input  logic [31:0] i_b1,
  input  logic [31:0] i_b2,
  input  logic [31:0] i_a1,
  input  logic [31:0] i_a2,
  input  logic        udp_tx_ready,
  output logic        udp_tx_valid,
  output logic        udp_tx_last,
  output logic [7:0]  udp_tx_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_drop,
  output logic        o_err
);

  localparam logic [7:0] FILT_LIMIT  = 8'(FILT_NUM);
  localparam logic [4:0] LAST_IDX    = 5'd20;
  localparam logic [4:0] PRE_LAST    = 5'd19;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state;
  logic [167:0]   active;      // frame in flight; top byte is the one on the bus
  logic [167:0]   pend;        // queued request snapshot
  logic           pend_valid;
  logic [4:0]     cnt;         // index of the byte currently presented

  logic           req_bad;
  logic           req_ok;
  logic [167:0]   req_word;

  // Out-of-range filter index wins over both accept and drop.
  assign req_bad  = i_send && (i_filt >= FILT_LIMIT);
  assign req_ok   = i_send && !req_bad;
  assign req_word = {i_filt, i_b0, i_b1, i_b2, i_a1, i_a2};

  // Active register shifts left per accepted byte, so the bus byte is its MSB.
  assign udp_tx_data = active[167:160];
  assign o_busy      = (state != S_IDLE) || pend_valid;

  // Frame sequencer: load, shift out 21 bytes, one S_DONE cycle, chain pending.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      active       <= '0;
      pend         <= '0;
      pend_valid   <= 1'b0;
      cnt          <= '0;
      udp_tx_valid <= 1'b0;
      udp_tx_last  <= 1'b0;
      o_done       <= 1'b0;
      o_drop       <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_drop <= 1'b0;
      o_err  <= req_bad;
      case (state)
        S_IDLE: begin
          if (req_ok) begin
            active       <= req_word;
            cnt          <= '0;
            udp_tx_valid <= 1'b1;
            udp_tx_last  <= 1'b0;
            state        <= S_SEND;
          end
        end
        S_SEND: begin
          if (req_ok) begin
            if (!pend_valid) begin
              pend       <= req_word;
              pend_valid <= 1'b1;
            end else begin
              o_drop <= 1'b1;
            end
          end
          if (udp_tx_valid && udp_tx_ready) begin
            if (cnt == LAST_IDX) begin
              udp_tx_valid <= 1'b0;
              udp_tx_last  <= 1'b0;
              o_done       <= 1'b1;
              state        <= S_DONE;
            end else begin
              active      <= {active[159:0], 8'h00};
              cnt         <= cnt + 5'd1;
              udp_tx_last <= (cnt == PRE_LAST);
            end
          end
        end
        S_DONE: begin
          if (pend_valid) begin
            // Pending frame starts; the freed slot may refill this same cycle.
            active       <= pend;
            cnt          <= '0;
            udp_tx_valid <= 1'b1;
            udp_tx_last  <= 1'b0;
            state        <= S_SEND;
            pend_valid   <= req_ok;
            if (req_ok) begin
              pend <= req_word;
            end
          end else if (req_ok) begin
            active       <= req_word;
            cnt          <= '0;
            udp_tx_valid <= 1'b1;
            udp_tx_last  <= 1'b0;
            state        <= S_SEND;
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          state        <= S_IDLE;
          udp_tx_valid <= 1'b0;
          udp_tx_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_udp_coef_sender.sv
// ============================================================================
// Module      : tb_udp_coef_sender
// Description : Randomised and directed bench for udp_coef_sender with a
//               queue-based scoreboard and a frame-occupancy reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_udp_coef_sender;

  localparam int FILT_NUM = 4;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_send;
  logic [7:0]  i_filt;
  logic [31:0] i_b0, i_b1, i_b2, i_a1, i_a2;
  logic        udp_tx_ready;
  logic        udp_tx_valid;
  logic        udp_tx_last;
  logic [7:0]  udp_tx_data;
  logic        o_busy, o_done, o_drop, o_err;

  int checks = 0;
  int errors = 0;

  udp_coef_sender #(.FILT_NUM(FILT_NUM)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_send       (i_send),
    .i_filt       (i_filt),
    .i_b0         (i_b0),
    .i_b1         (i_b1),
    .i_b2         (i_b2),
    .i_a1         (i_a1),
    .i_a2         (i_a2),
    .udp_tx_ready (udp_tx_ready),
    .udp_tx_valid (udp_tx_valid),
    .udp_tx_last  (udp_tx_last),
    .udp_tx_data  (udp_tx_data),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_drop       (o_drop),
    .o_err        (o_err)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard / reference model ----------------
  logic [8:0] bq[$];          // expected {last, data} bytes in order
  int         outstanding = 0; // accepted frames whose last byte is not yet taken
  int         cur_idx = 0;     // byte position presented within the current frame
  logic       armed = 1'b0;
  logic       exp_valid = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;
  logic       exp_drop = 1'b0, exp_err = 1'b0;
  logic       stall_prev = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare this cycle's outputs, then predict the next cycle.
  always @(negedge clk) begin
    logic         hs;
    logic         completing;
    logic [8:0]   e;
    logic [167:0] w;
    if (armed) begin
      check("valid", {31'd0, udp_tx_valid}, {31'd0, exp_valid});
      check("busy",  {31'd0, o_busy},       {31'd0, exp_busy});
      check("done",  {31'd0, o_done},       {31'd0, exp_done});
      check("drop",  {31'd0, o_drop},       {31'd0, exp_drop});
      check("err",   {31'd0, o_err},        {31'd0, exp_err});
      if (stall_prev) begin
        check("hold_valid", {31'd0, udp_tx_valid}, 32'd1);
        check("hold_data",  {24'd0, udp_tx_data},  {24'd0, prev_data});
        check("hold_last",  {31'd0, udp_tx_last},  {31'd0, prev_last});
      end
    end
    if (i_rst) begin
      bq.delete();
      outstanding = 0;
      cur_idx     = 0;
      exp_valid   = 1'b0;
      exp_busy    = 1'b0;
      exp_done    = 1'b0;
      exp_drop    = 1'b0;
      exp_err     = 1'b0;
      stall_prev  = 1'b0;
      armed       = 1'b1;
    end else if (armed) begin
      exp_done   = 1'b0;
      exp_drop   = 1'b0;
      exp_err    = 1'b0;
      completing = 1'b0;
      hs = udp_tx_valid && udp_tx_ready;
      if (hs) begin
        if (bq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %h expected none at %0t", udp_tx_data, $time);
        end else begin
          e = bq.pop_front();
          check("data", {24'd0, udp_tx_data}, {24'd0, e[7:0]});
          check("last", {31'd0, udp_tx_last}, {31'd0, e[8]});
          completing = e[8];
        end
        cur_idx = completing ? 0 : cur_idx + 1;
      end
      if (i_send) begin
        if (i_filt >= 8'(FILT_NUM)) begin
          exp_err = 1'b1;
        end else if (outstanding < 2) begin
          w = {i_filt, i_b0, i_b1, i_b2, i_a1, i_a2};
          for (int k = 0; k < 21; k++) begin
            bq.push_back({(k == 20), w[167 - 8*k -: 8]});
          end
          outstanding++;
        end else begin
          exp_drop = 1'b1;
        end
      end
      if (completing) begin
        outstanding--;
        exp_done = 1'b1;
      end
      exp_valid  = (outstanding > 0) && !completing;
      exp_busy   = (outstanding > 0) || completing;
      stall_prev = udp_tx_valid && !udp_tx_ready;
      prev_data  = udp_tx_data;
      prev_last  = udp_tx_last;
    end
  end

  // ---------------- stimulus ----------------
  int mode = 0;      // 0: ready high, 1: toggle, 2: random
  int hold_cnt = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    i_rst  = 1'b0;
    i_send = 1'b0;
    i_filt = 8'($urandom);
    i_b0   = $urandom;
    i_b1   = $urandom;
    i_b2   = $urandom;
    i_a1   = $urandom;
    i_a2   = $urandom;
    if (hold_cnt > 0) begin
      udp_tx_ready = 1'b0;
      hold_cnt--;
    end else begin
      case (mode)
        0:       udp_tx_ready = 1'b1;
        1:       udp_tx_ready = ~udp_tx_ready;
        default: udp_tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  task automatic req(input logic [7:0] f, input logic [31:0] b0, input logic [31:0] b1,
                     input logic [31:0] b2, input logic [31:0] a1, input logic [31:0] a2);
    i_send = 1'b1;
    i_filt = f;
    i_b0 = b0; i_b1 = b1; i_b2 = b2; i_a1 = a1; i_a2 = a2;
    tick();
  endtask

  task automatic req_rand(input logic [7:0] f);
    req(f, $urandom, $urandom, $urandom, $urandom, $urandom);
  endtask

  task automatic wait_idx(input int n);
    bit hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      if (udp_tx_valid && cur_idx == n) hit = 1'b1;
      else tick();
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL wait_idx: byte %0d never presented (got cur_idx %0d)", n, cur_idx);
    end
  endtask

  task automatic wait_idle();
    bit hit = 1'b0;
    for (int i = 0; i < 600 && !hit; i++) begin
      if (!o_busy && bq.size() == 0 && !o_done) hit = 1'b1;
      else tick();
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL wait_idle: busy %0b with %0d bytes still expected", o_busy, bq.size());
    end
    tick();
  endtask

  initial begin
    i_rst = 1'b1; i_send = 1'b0; i_filt = '0;
    i_b0 = '0; i_b1 = '0; i_b2 = '0; i_a1 = '0; i_a2 = '0;
    udp_tx_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    tick();
    tick();

    // 1: single frame at full rate
    mode = 0;
    req(8'h02, 32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00, 32'h0A0B0C0D);
    wait_idle();

    // 2: toggling ready plus a 5-cycle stall at byte 7
    mode = 1;
    req_rand(8'h03);
    wait_idx(7);
    udp_tx_ready = 1'b0;
    hold_cnt = 4;
    wait_idle();

    // 3: queued request during byte 10
    mode = 0;
    req_rand(8'h00);
    wait_idx(10);
    req_rand(8'h01);
    wait_idle();

    // 4: two drops while the pending slot is full
    req_rand(8'h02);
    req_rand(8'h01);
    tick();
    req_rand(8'h03);
    req_rand(8'h00);
    wait_idle();

    // 5: bad index in idle, then during a frame with pending occupied
    req_rand(8'h04);
    tick();
    tick();
    req_rand(8'h01);
    req_rand(8'h02);
    tick();
    req_rand(8'h04);
    req_rand(8'hFF);
    wait_idle();

    // 6: reset mid-frame with a pending request, then restart
    req_rand(8'h00);
    req_rand(8'h03);
    wait_idx(12);
    i_rst = 1'b1;
    tick();
    tick();
    req_rand(8'h02);
    wait_idle();

    // random traffic
    mode = 2;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        i_send = 1'b1;
        i_filt = 8'($urandom_range(0, 5));
      end
      if ($urandom_range(0, 299) == 0) i_rst = 1'b1;
      tick();
    end
    mode = 0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/udp_coef_sender.md
Name: udp_coef_sender

Overview:
Serialises one biquad coefficient set into a 21-byte UDP payload on a byte stream with valid/ready/last handshake. It is the transmit counterpart of the equalizer coefficient parser and uses the same payload layout, so coefficient readback frames round-trip unchanged. It sits between the equalizer register bank and the UDP TX path. It holds one active frame plus one pending request.

Parameters:
FILT_NUM, 4, number of filter slots; a request with i_filt >= FILT_NUM is rejected.

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous, active-high reset
i_send  input  1  single-cycle request to transmit the operands presented in the same cycle
i_filt  input  8  filter index (payload byte 0)
i_b0  input  32  coefficient b0
i_b1  input  32  coefficient b1
i_b2  input  32  coefficient b2
i_a1  input  32  coefficient a1
i_a2  input  32  coefficient a2
udp_tx_ready  input  1  sink accepts the current byte
udp_tx_valid  output  1  udp_tx_data holds a valid byte
udp_tx_last  output  1  current byte is byte 20 of the frame
udp_tx_data  output  8  payload byte
o_busy  output  1  the state is not S_IDLE, or the pending slot is occupied
o_done  output  1  one-cycle pulse after the last byte of a frame is accepted
o_drop  output  1  one-cycle pulse: request lost because the pending slot was full
o_err  output  1  one-cycle pulse: request rejected because i_filt >= FILT_NUM

Behaviour:
- Reset (synchronous, active-high, i_rst):
  - All outputs go to 0 and the state returns to S_IDLE.
  - The byte counter is cleared and the pending slot is emptied.
  - Reset mid-frame aborts the frame: udp_tx_valid is 0 from the next cycle, and o_done is not raised.
- Payload word (168 bits) is {filt, b0, b1, b2, a1, a2}, sent MSB first:
  - byte 0 = filt
  - bytes 1..4 = b0[31:24] .. b0[7:0]
  - and so on through a2
  - byte 20 = a2[7:0]
- Operands are snapshotted when a request is accepted. Input changes after that point do not affect the frame in flight.
- States:
  - S_IDLE: a valid i_send loads the active register, clears the counter and moves to S_SEND. udp_tx_valid is 1 from the next cycle (latency 1).
  - S_SEND:
    - udp_tx_valid = 1 and udp_tx_data = active byte[counter].
    - udp_tx_last = 1 only when counter == 20.
    - A byte completes on valid && ready; the counter then increments.
    - When !ready, data, last and valid hold stable.
    - A handshake at counter 20 moves the state to S_DONE.
  - S_DONE (1 cycle):
    - o_done = 1 and udp_tx_valid = 0.
    - If the pending slot is occupied: pending moves to active, the counter clears, the state goes to S_SEND, and the pending slot is freed. An i_send in this cycle loads the freed pending slot.
    - Else, if i_send is valid: it loads active and the state goes to S_SEND.
    - Else: the state goes to S_IDLE.
- i_send during S_SEND:
  - Pending slot empty: the request is stored in pending.
  - Pending slot full: o_drop pulses the next cycle and the request is discarded; the existing pending request is kept.
- Range check takes priority over accept and over drop:
  - i_filt >= FILT_NUM makes o_err pulse the next cycle.
  - No state or slot change occurs.
- Minimum gap between frames is one idle-valid cycle (the S_DONE cycle).
- Best-case frame time is 21 cycles at ready = 1.

Test Plan:
1. Single frame, ready = 1.
   - Stimulus: i_send with filt=0x02, b0=0x11223344, b1=0x55667788, b2=0x99AABBCC, a1=0xDDEEFF00, a2=0x0A0B0C0D.
   - Response: 21 consecutive bytes 02,11,22,…,0C,0D; last on byte 20 (0x0D); o_done the cycle after; o_busy 0 after that.
2. Backpressure.
   - Stimulus: ready toggles 1/0 every cycle; additionally, ready is held 0 for 5 cycles at byte 7.
   - Response: data, last and valid stay stable while ready = 0; byte order is unchanged; total bytes = 21; operand changes after accept are ignored.
3. Queued request.
   - Stimulus: a second i_send (filt=0x01) during byte 10 of frame A.
   - Response: frame A completes; o_done; the next cycle valid = 1 with byte 0 = 0x01; two o_done pulses in total.
4. Drop.
   - Stimulus: third and fourth i_send during frame A, while the pending slot is full.
   - Response: o_drop pulses once for each; only the first queued frame follows A.
5. Bad index.
   - Stimulus: i_send with filt=0x04 (FILT_NUM=4), in S_IDLE and again in S_SEND.
   - Response: o_err pulses in both cases; valid stays 0 in S_IDLE; the pending slot is unchanged in S_SEND.
6. Reset mid-frame.
   - Stimulus: i_rst at byte 12, with one request pending.
   - Response: valid = 0 the next cycle; no o_done; pending is cleared; a fresh i_send restarts at byte 0.
